// File: rtl/hazard_ctrl_if.sv
// Pipeline-side hazard signals: register indices, write-backs and memory
// handshake in; stage stall/flush controls and forwarding selects out.
interface hazard_ctrl_if;
    logic       trigger;
    logic [4:0] rs1D;
    logic [4:0] rs2D;
    logic [4:0] rs1E;
    logic [4:0] rs2E;
    logic [4:0] rdE;
    logic       loadE;
    logic       pcsrcE;
    logic       regwriteM;
    logic [4:0] rdM;
    logic       regwriteW;
    logic [4:0] rdW;
    logic       mem_req_M;
    logic       mem_ready;
    logic       stallF;
    logic       stallD;
    logic       stallE;
    logic       stallM;
    logic       flushD;
    logic       flushE;
    logic       flushW;
    logic [1:0] forwardAE;
    logic [1:0] forwardBE;
    logic       mem_err;

    // Pipeline datapath side.
    modport master (
        output trigger, rs1D, rs2D, rs1E, rs2E, rdE, loadE, pcsrcE,
               regwriteM, rdM, regwriteW, rdW, mem_req_M, mem_ready,
        input  stallF, stallD, stallE, stallM, flushD, flushE, flushW,
               forwardAE, forwardBE, mem_err
    );

    // Hazard controller side.
    modport slave (
        input  trigger, rs1D, rs2D, rs1E, rs2E, rdE, loadE, pcsrcE,
               regwriteM, rdM, regwriteW, rdW, mem_req_M, mem_ready,
        output stallF, stallD, stallE, stallM, flushD, flushE, flushW,
               forwardAE, forwardBE, mem_err
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: start-up hold, memory-wait freeze,
// branch flush, load-use bubble and EX forwarding.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
    parameter int WIDTH       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
`ifdef HAZARD_PERF_CNT_EN
    output logic [WIDTH-1:0] stall_cnt,
    output logic [WIDTH-1:0] flush_cnt,
`endif
    hazard_ctrl_if.slave     hz
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    if (MEM_TIMEOUT < 1 || WIDTH < 1) begin : g_param_check
        $error("hazard_ctrl: MEM_TIMEOUT and WIDTH must both be >= 1");
    end

    typedef enum logic [1:0] {
        WAIT_TRIG = 2'd0,
        RUN       = 2'd1,
        MEM_WAIT  = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_mem_err;

    logic             w_busy;
    logic             w_load_use;
    logic             w_advance;
    logic [CNT_W-1:0] w_wait_inc;
    logic             w_timeout;
    logic             w_stallF;
    logic             w_stallD;
    logic             w_stallE;
    logic             w_stallM;
    logic             w_flushD;
    logic             w_flushE;
    logic             w_flushW;

    assign w_busy     = hz.mem_req_M & ~hz.mem_ready;
    assign w_load_use = hz.loadE & (hz.rdE != 5'd0) &
                        ((hz.rdE == hz.rs1D) | (hz.rdE == hz.rs2D));
    // Cycles where the pipeline is free to move: branch/load-use apply here.
    assign w_advance  = ((r_state == RUN) & ~w_busy) |
                        ((r_state == MEM_WAIT) & hz.mem_ready);
    // The counter tracks consecutive busy cycles, the first RUN cycle included.
    assign w_wait_inc = r_wait_cnt + CNT_W'(1);
    assign w_timeout  = (w_wait_inc == CNT_W'(MEM_TIMEOUT));

    always_comb begin
        w_stallF = 1'b0;
        w_stallD = 1'b0;
        w_stallE = 1'b0;
        w_stallM = 1'b0;
        w_flushD = 1'b0;
        w_flushE = 1'b0;
        w_flushW = 1'b0;
        if (r_state == RUN || r_state == MEM_WAIT) begin
            if (w_advance) begin
                if (hz.pcsrcE) begin
                    w_flushD = 1'b1;
                    w_flushE = 1'b1;
                end else if (w_load_use) begin
                    w_stallF = 1'b1;
                    w_stallD = 1'b1;
                    w_flushE = 1'b1;
                end
            end else begin
                w_stallF = 1'b1;
                w_stallD = 1'b1;
                w_stallE = 1'b1;
                w_stallM = 1'b1;
                w_flushW = 1'b1;
            end
        end else begin
            w_stallF = 1'b1;
            w_flushD = 1'b1;
            w_flushE = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= WAIT_TRIG;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            case (r_state)
                WAIT_TRIG: begin
                    r_wait_cnt <= '0;
                    if (hz.trigger) r_state <= RUN;
                end
                RUN, MEM_WAIT: begin
                    if (!w_busy) begin
                        r_state    <= RUN;
                        r_wait_cnt <= '0;
                    end else if (w_timeout) begin
                        // Abandon the access; the pipeline resumes in RUN.
                        r_state    <= RUN;
                        r_wait_cnt <= '0;
                        r_mem_err  <= 1'b1;
                    end else begin
                        r_state    <= MEM_WAIT;
                        r_wait_cnt <= w_wait_inc;
                    end
                end
                default: begin
                    r_state    <= WAIT_TRIG;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

    logic [4:0] w_rs_e [2];
    logic [1:0] w_fwd  [2];

    assign w_rs_e[0] = hz.rs1E;
    assign w_rs_e[1] = hz.rs2E;

    // M-stage result is younger than W-stage, so it wins on a double match.
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        assign w_fwd[gi] =
            ((w_rs_e[gi] != 5'd0) && hz.regwriteM && (hz.rdM == w_rs_e[gi])) ? 2'b10 :
            ((w_rs_e[gi] != 5'd0) && hz.regwriteW && (hz.rdW == w_rs_e[gi])) ? 2'b01 :
                                                                                2'b00;
    end

    assign hz.stallF    = w_stallF;
    assign hz.stallD    = w_stallD;
    assign hz.stallE    = w_stallE;
    assign hz.stallM    = w_stallM;
    assign hz.flushD    = w_flushD;
    assign hz.flushE    = w_flushE;
    assign hz.flushW    = w_flushW;
    assign hz.forwardAE = w_fwd[0];
    assign hz.forwardBE = w_fwd[1];
    assign hz.mem_err   = r_mem_err;

`ifdef HAZARD_PERF_CNT_EN
    logic [WIDTH-1:0] r_stall_cnt;
    logic [WIDTH-1:0] r_flush_cnt;
    logic             w_stall_evt;
    logic             w_flush_br;

    assign w_stall_evt = w_stallF & ((r_state == RUN) | (r_state == MEM_WAIT));
    assign w_flush_br  = w_advance & hz.pcsrcE;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_evt) r_stall_cnt <= r_stall_cnt + WIDTH'(1);
            if (w_flush_br)  r_flush_cnt <= r_flush_cnt + WIDTH'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule
